// File: rtl/local_store_dp.sv
// Odd-pipe quadword load/store unit with a DMA side port sharing one single-ported array.
// Loads return to WB LAT_STAGES cycles after issue; a bounded-wait arbiter lets DMA preempt issue.
//
// state    | meaning
// ARB_IDLE | no DMA request has been refused since the last grant or request drop
// ARB_WAIT | DMA request refused wait_cnt cycles in a row; preempts SPU at DMA_MAX_WAIT
module local_store_dp #(
   parameter int LS_BYTES     = 32768,
   parameter int LAT_STAGES   = 6,
   parameter int DMA_MAX_WAIT = 4,
   parameter int QW_AW        = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [0:10]      op,
   input  logic [2:0]       format,
   input  logic [0:6]       rt_addr,
   input  logic [0:127]     ra,
   input  logic [0:127]     rb,
   input  logic [0:127]     rt_st_odd,
   input  logic [0:17]      imm,
   input  logic             reg_write,
   output logic             ls_stall,
   output logic [0:127]     rt_wb,
   output logic [0:6]       rt_addr_wb,
   output logic             reg_write_wb,
   input  logic             dma_req,
   input  logic             dma_we,
   input  logic [QW_AW-1:0] dma_addr,
   input  logic [0:127]     dma_wdata,
   output logic             dma_gnt,
   output logic             dma_rvalid,
   output logic [0:127]     dma_rdata
);

   localparam int          WCW  = (DMA_MAX_WAIT > 0) ? $clog2(DMA_MAX_WAIT + 1) : 1;
   localparam int          QW_N = LS_BYTES / 16;
   localparam logic [31:0] LSLR = 32'(LS_BYTES - 1);

   typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;

   logic fmt_rr, fmt_ri10, fmt_ri16;
   logic op_lqx, op_lqd, op_lqa, op_stqx, op_stqd, op_stqa;
   logic is_load, is_store, spu_ls;

   assign fmt_rr   = (format == 3'd0);
   assign fmt_ri10 = (format == 3'd4);
   assign fmt_ri16 = (format == 3'd5);

   assign op_lqx  = fmt_rr   && (op       == 11'b00111000100);
   assign op_lqd  = fmt_ri10 && (op[0:7]  == 8'b00110100);
   assign op_lqa  = fmt_ri16 && (op[0:8]  == 9'b001100001);
   assign op_stqx = fmt_rr   && (op       == 11'b00101000100);
   assign op_stqd = fmt_ri10 && (op[0:7]  == 8'b00100100);
   assign op_stqa = fmt_ri16 && (op[0:8]  == 9'b001000001);

   assign is_load  = op_lqx || op_lqd || op_lqa;
   assign is_store = op_stqx || op_stqd || op_stqa;
   assign spu_ls   = is_load || is_store;

   logic [31:0]      ra_w0, rb_w0, i10_ext, i16_ext, ea, ea_m;
   logic [QW_AW-1:0] spu_addr;

   assign ra_w0   = ra[0:31];
   assign rb_w0   = rb[0:31];
   assign i10_ext = {{22{imm[8]}}, imm[8:17]} << 4;
   assign i16_ext = {{16{imm[2]}}, imm[2:17]} << 2;

   always_comb begin
      ea = i16_ext;
      if (op_lqx || op_stqx)
         ea = ra_w0 + rb_w0;
      else if (op_lqd || op_stqd)
         ea = ra_w0 + i10_ext;
   end

   // out-of-range addresses wrap inside the store rather than faulting
   assign ea_m     = ea & LSLR & ~32'hF;
   assign spu_addr = ea_m[QW_AW+3:4];

   logic unused_bits;
   assign unused_bits = ^{ra[32:127], rb[32:127], imm[0:1], ea_m};

   arb_state_t     state, state_nx;
   logic [WCW-1:0] wait_cnt, cnt_nx;

   always_comb begin
      state_nx = state;
      cnt_nx   = wait_cnt;
      dma_gnt  = 1'b0;
      case (state)
         ARB_IDLE: dma_gnt = dma_req && (!spu_ls || (DMA_MAX_WAIT == 0));
         ARB_WAIT: dma_gnt = dma_req && (!spu_ls || (wait_cnt == WCW'(DMA_MAX_WAIT)));
      endcase
      if (dma_req && !dma_gnt) begin
         state_nx = ARB_WAIT;
         cnt_nx   = wait_cnt + WCW'(1);
      end else begin
         state_nx = ARB_IDLE;
         cnt_nx   = '0;
      end
   end

   assign ls_stall = spu_ls && dma_gnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ARB_IDLE;
         wait_cnt   <= '0;
         dma_rvalid <= 1'b0;
      end else begin
         state      <= state_nx;
         wait_cnt   <= cnt_nx;
         dma_rvalid <= dma_gnt && !dma_we;
      end
   end

   logic [QW_AW-1:0] acc_addr;
   logic             acc_we, acc_rd;
   logic [0:127]     acc_wdata;

   always_comb begin
      acc_addr  = spu_addr;
      acc_we    = 1'b0;
      acc_rd    = 1'b0;
      acc_wdata = rt_st_odd;
      if (dma_gnt) begin
         acc_addr  = dma_addr;
         acc_we    = dma_we;
         acc_rd    = !dma_we;
         acc_wdata = dma_wdata;
      end else if (spu_ls) begin
         acc_we = is_store;
         acc_rd = is_load;
      end
   end

   logic [0:127] mem [QW_N];
   logic [0:127] mem_q;

   // array has no reset; mem_q is only observed through valid-gated paths
   always_ff @(posedge clk) begin
      if (acc_we) mem[acc_addr] <= acc_wdata;
      if (acc_rd) mem_q <= mem[acc_addr];
   end

   assign dma_rdata = dma_rvalid ? mem_q : '0;

   logic         ld_q  [1:LAT_STAGES];
   logic         rw_q  [1:LAT_STAGES];
   logic [0:6]   rt_q  [1:LAT_STAGES];
   logic [0:127] dat_q [2:LAT_STAGES];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 1; i <= LAT_STAGES; i++) begin
            ld_q[i] <= 1'b0;
            rw_q[i] <= 1'b0;
            rt_q[i] <= '0;
         end
         for (int i = 2; i <= LAT_STAGES; i++) dat_q[i] <= '0;
      end else begin
         ld_q[1] <= is_load && !ls_stall;
         rw_q[1] <= reg_write;
         rt_q[1] <= rt_addr;
         dat_q[2] <= ld_q[1] ? mem_q : '0;
         for (int i = 2; i <= LAT_STAGES; i++) begin
            ld_q[i] <= ld_q[i-1];
            rw_q[i] <= rw_q[i-1];
            rt_q[i] <= rt_q[i-1];
         end
         for (int i = 3; i <= LAT_STAGES; i++) dat_q[i] <= dat_q[i-1];
      end
   end

   assign rt_wb        = dat_q[LAT_STAGES];
   assign reg_write_wb = ld_q[LAT_STAGES] && rw_q[LAT_STAGES];
   assign rt_addr_wb   = ld_q[LAT_STAGES] ? rt_q[LAT_STAGES] : '0;

endmodule

// File: tb/tb_local_store_dp.sv
// Directed bench for local_store_dp: table of load/store vectors plus arbiter, DMA and reset sequences.
module tb_local_store_dp;

   localparam int LAT = 6;

   localparam logic [10:0] LQX  = 11'b00111000100;
   localparam logic [10:0] LQD  = 11'b00110100000;
   localparam logic [10:0] LQA  = 11'b00110000100;
   localparam logic [10:0] STQX = 11'b00101000100;
   localparam logic [10:0] STQD = 11'b00100100000;
   localparam logic [10:0] STQA = 11'b00100000100;
   localparam logic [10:0] FA   = 11'b01011000100;

   localparam logic [127:0] DA5 = {16{8'hA5}};
   localparam logic [127:0] D11 = {16{8'h11}};
   localparam logic [127:0] D22 = {16{8'h22}};
   localparam logic [127:0] D33 = {16{8'h33}};
   localparam logic [127:0] D5A = {16{8'h5A}};

   logic         clk, reset;
   logic [10:0]  op;
   logic [2:0]   format;
   logic [6:0]   rt_addr;
   logic [127:0] ra, rb, rt_st_odd;
   logic [17:0]  imm;
   logic         reg_write;
   logic         ls_stall;
   logic [127:0] rt_wb;
   logic [6:0]   rt_addr_wb;
   logic         reg_write_wb;
   logic         dma_req, dma_we;
   logic [10:0]  dma_addr;
   logic [127:0] dma_wdata;
   logic         dma_gnt, dma_rvalid;
   logic [127:0] dma_rdata;

   int total = 0;
   int bad   = 0;

   local_store_dp dut (
      .clk(clk), .reset(reset), .op(op), .format(format), .rt_addr(rt_addr),
      .ra(ra), .rb(rb), .rt_st_odd(rt_st_odd), .imm(imm), .reg_write(reg_write),
      .ls_stall(ls_stall), .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [10:0]  op;
      logic [2:0]   fmt;
      logic [31:0]  ra0;
      logic [31:0]  rb0;
      logic [17:0]  imm;
      logic [6:0]   rt;
      logic         rw;
      logic [127:0] sd;
      logic         ld;
      logic [127:0] exp_wb;
      logic         exp_rw;
   } vec_t;

   vec_t tbl [14];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bubble();
      op = '0; format = 3'd7; rt_addr = '0; ra = '0; rb = '0;
      imm = '0; reg_write = 1'b0; rt_st_odd = '0;
   endtask

   task automatic drive(input vec_t v);
      op = v.op; format = v.fmt; ra = {v.ra0, 96'h0}; rb = {v.rb0, 96'h0};
      imm = v.imm; rt_addr = v.rt; reg_write = v.rw; rt_st_odd = v.sd;
   endtask

   task automatic run_row(input vec_t v, input int idx);
      drive(v);
      #1;
      check($sformatf("row%0d_stall", idx), ls_stall, 1'b0);
      tick();
      bubble();
      for (int k = 1; k < LAT; k++) begin
         if (k == LAT - 1) check($sformatf("row%0d_early", idx), reg_write_wb, 1'b0);
         tick();
      end
      check($sformatf("row%0d_wb", idx), rt_wb, v.exp_wb);
      check($sformatf("row%0d_rw", idx), reg_write_wb, v.exp_rw);
      if (v.ld) check($sformatf("row%0d_rt", idx), rt_addr_wb, v.rt);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t lq;
      tbl[0]  = '{STQX, 3'd0, 32'h10,       32'hF0, 18'h0,     7'd0,  1'b0, DA5, 1'b0, '0,  1'b0};
      tbl[1]  = '{LQX,  3'd0, 32'h10,       32'hF0, 18'h0,     7'd3,  1'b1, '0,  1'b1, DA5, 1'b1};
      tbl[2]  = '{STQD, 3'd4, 32'h7FF0,     32'h0,  18'h1,     7'd0,  1'b0, D11, 1'b0, '0,  1'b0};
      tbl[3]  = '{LQA,  3'd5, 32'h0,        32'h0,  18'h3,     7'd5,  1'b1, '0,  1'b1, D11, 1'b1};
      tbl[4]  = '{LQD,  3'd4, 32'h7FF0,     32'h0,  18'h1,     7'd6,  1'b1, '0,  1'b1, D11, 1'b1};
      tbl[5]  = '{LQA,  3'd5, 32'h0,        32'h0,  18'h40,    7'd7,  1'b0, '0,  1'b1, DA5, 1'b0};
      tbl[6]  = '{STQA, 3'd5, 32'h0,        32'h0,  18'h0FFFC, 7'd0,  1'b0, D22, 1'b0, '0,  1'b0};
      tbl[7]  = '{LQX,  3'd0, 32'hFFFFFFF0, 32'h0,  18'h0,     7'd9,  1'b1, '0,  1'b1, D22, 1'b1};
      tbl[8]  = '{LQD,  3'd4, 32'h0,        32'h0,  18'h003FF, 7'd10, 1'b1, '0,  1'b1, D22, 1'b1};
      tbl[9]  = '{FA,   3'd0, 32'h10,       32'hF0, 18'h0,     7'd11, 1'b1, '0,  1'b0, '0,  1'b0};
      tbl[10] = '{LQX,  3'd4, 32'h10,       32'hF0, 18'h0,     7'd12, 1'b1, '0,  1'b0, '0,  1'b0};
      tbl[11] = '{STQD, 3'd4, 32'h105,      32'h0,  18'h0,     7'd0,  1'b0, D33, 1'b0, '0,  1'b0};
      tbl[12] = '{LQD,  3'd4, 32'h10C,      32'h0,  18'h0,     7'd13, 1'b1, '0,  1'b1, D33, 1'b1};
      tbl[13] = '{LQX,  3'd0, 32'h8010,     32'hF0, 18'h0,     7'd14, 1'b1, '0,  1'b1, D33, 1'b1};

      reset = 1'b0;
      bubble();
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      #1;
      check("rst_wb", rt_wb, '0);
      check("rst_rw", reg_write_wb, 1'b0);
      check("rst_rt", rt_addr_wb, '0);
      check("rst_stall", ls_stall, 1'b0);
      check("rst_gnt", dma_gnt, 1'b0);
      check("rst_rvalid", dma_rvalid, 1'b0);
      check("rst_rdata", dma_rdata, '0);
      tick(); tick();
      reset = 1'b1;
      tick();

      for (int i = 0; i < 14; i++) run_row(tbl[i], i);

      // DMA read preempts after DMA_MAX_WAIT refused cycles of back-to-back loads
      lq = tbl[1];
      drive(lq);
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 11'h010;
      for (int c = 1; c <= 5; c++) begin
         #1;
         check($sformatf("arb_stall_c%0d", c), ls_stall, c == 5);
         check($sformatf("arb_gnt_c%0d", c), dma_gnt, c == 5);
         tick();
      end
      dma_req = 1'b0;
      #1;
      check("arb_rvalid", dma_rvalid, 1'b1);
      check("arb_rdata", dma_rdata, D33);
      check("arb_stall_noreq", ls_stall, 1'b0);
      tick();
      check("arb_rvalid_once", dma_rvalid, 1'b0);

      // refusal count restarts when the request drops
      dma_req = 1'b1;
      tick(); tick();
      dma_req = 1'b0;
      tick();
      dma_req = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         #1;
         check($sformatf("clr_gnt_c%0d", c), dma_gnt, c == 5);
         tick();
      end
      dma_req = 1'b0;
      bubble();
      for (int k = 0; k < LAT + 1; k++) tick();

      // DMA write with idle SPU is granted at once; SPU load sees it
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 11'h020; dma_wdata = D5A;
      #1;
      check("dmaw_gnt", dma_gnt, 1'b1);
      check("dmaw_stall", ls_stall, 1'b0);
      tick();
      dma_req = 1'b0; dma_we = 1'b0;
      check("dmaw_no_rvalid", dma_rvalid, 1'b0);
      lq = '{LQA, 3'd5, 32'h0, 32'h0, 18'h80, 7'd12, 1'b1, '0, 1'b1, D5A, 1'b1};
      run_row(lq, 100);

      // reset with a load in flight drops it
      drive(tbl[1]);
      tick();
      bubble();
      tick();
      reset = 1'b0;
      #1;
      check("midrst_wb", rt_wb, '0);
      check("midrst_rw", reg_write_wb, 1'b0);
      tick();
      reset = 1'b1;
      for (int k = 1; k <= 2 * LAT; k++) begin
         check($sformatf("midrst_rw_c%0d", k), reg_write_wb, 1'b0);
         tick();
      end

      // reset cancels a pending DMA read response
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 11'h020;
      tick();
      dma_req = 1'b0;
      check("rvrst_pre", dma_rvalid, 1'b1);
      reset = 1'b0;
      #1;
      check("rvrst_rvalid", dma_rvalid, 1'b0);
      check("rvrst_rdata", dma_rdata, '0);
      tick();
      reset = 1'b1;
      tick();
      check("rvrst_after", dma_rvalid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
